// File: rtl/game_control.sv
// Per-frame sequencer for the game datapath. It steps through the update stages, then the three
// drawers, and a watchdog forces any stalled draw stage to advance.
module game_control #(
    parameter int          INIT_CYCLES  = 4,
    parameter logic [23:0] DRAW_TIMEOUT = 24'd200000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pause,
    input  logic        idle_done,
    input  logic        draw_map_done,
    input  logic        draw_link_done,
    input  logic        draw_enemies_done,
    output logic        init,
    output logic        idle,
    output logic        gen_move,
    output logic        check_collide,
    output logic        apply_act_link,
    output logic        move_enemies,
    output logic        draw_map,
    output logic        draw_link,
    output logic        draw_enemies,
    output logic [15:0] frame_count,
    output logic        timeout_flag,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_INIT           = 4'd0,
        S_IDLE           = 4'd1,
        S_GEN_MOVE       = 4'd2,
        S_CHECK_COLLIDE  = 4'd3,
        S_APPLY_ACT_LINK = 4'd4,
        S_MOVE_ENEMIES   = 4'd5,
        S_DRAW_MAP       = 4'd6,
        S_DRAW_LINK      = 4'd7,
        S_DRAW_ENEMIES   = 4'd8
    } state_t;

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    state_t              r_state;
    logic [INIT_W-1:0]   r_init_cnt;
    logic [23:0]         r_wdog;
    logic [15:0]         r_frame_count;
    logic                r_timeout_flag;

    logic w_in_draw;
    logic w_done_sel;
    logic w_done_qual;
    logic w_wdog_expired;
    logic w_draw_advance;

    // A zero watchdog marks the first cycle of a draw state, where a stale done level is masked.
    always_comb begin
        w_in_draw  = 1'b0;
        w_done_sel = 1'b0;
        case (r_state)
            S_DRAW_MAP:     begin w_in_draw = 1'b1; w_done_sel = draw_map_done;     end
            S_DRAW_LINK:    begin w_in_draw = 1'b1; w_done_sel = draw_link_done;    end
            S_DRAW_ENEMIES: begin w_in_draw = 1'b1; w_done_sel = draw_enemies_done; end
            default:        ;
        endcase
        w_done_qual    = w_done_sel && (r_wdog != 24'd0);
        w_wdog_expired = w_in_draw && (r_wdog == DRAW_TIMEOUT - 24'd1);
        w_draw_advance = w_done_qual || w_wdog_expired;
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= S_INIT;
            r_init_cnt     <= '0;
            r_wdog         <= '0;
            r_frame_count  <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            if (w_draw_advance || !w_in_draw) r_wdog <= '0;
            else                              r_wdog <= r_wdog + 24'd1;

            if (w_draw_advance && !w_done_qual) r_timeout_flag <= 1'b1;

            case (r_state)
                S_INIT: begin
                    if (r_init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
                        r_state    <= S_IDLE;
                        r_init_cnt <= '0;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                S_IDLE:           if (idle_done && !pause) r_state <= S_GEN_MOVE;
                S_GEN_MOVE:       r_state <= S_CHECK_COLLIDE;
                S_CHECK_COLLIDE:  r_state <= S_APPLY_ACT_LINK;
                S_APPLY_ACT_LINK: r_state <= S_MOVE_ENEMIES;
                S_MOVE_ENEMIES:   r_state <= S_DRAW_MAP;
                S_DRAW_MAP:       if (w_draw_advance) r_state <= S_DRAW_LINK;
                S_DRAW_LINK:      if (w_draw_advance) r_state <= S_DRAW_ENEMIES;
                S_DRAW_ENEMIES: begin
                    if (w_draw_advance) begin
                        r_state       <= S_IDLE;
                        r_frame_count <= r_frame_count + 16'd1;
                    end
                end
                default: begin
                    r_state    <= S_INIT;
                    r_init_cnt <= '0;
                end
            endcase
        end
    end

    // Moore decode straight off the state register; illegal codes light no strobe.
    assign init           = (r_state == S_INIT);
    assign idle           = (r_state == S_IDLE);
    assign gen_move       = (r_state == S_GEN_MOVE);
    assign check_collide  = (r_state == S_CHECK_COLLIDE);
    assign apply_act_link = (r_state == S_APPLY_ACT_LINK);
    assign move_enemies   = (r_state == S_MOVE_ENEMIES);
    assign draw_map       = (r_state == S_DRAW_MAP);
    assign draw_link      = (r_state == S_DRAW_LINK);
    assign draw_enemies   = (r_state == S_DRAW_ENEMIES);
    assign frame_count    = r_frame_count;
    assign timeout_flag   = r_timeout_flag;
    assign state_dbg      = r_state;

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control: reset/init, full frames, stale-done mask, watchdog timeout,
// pause, frame counter wrap and mid-frame reset, checked one cycle at a time.
module tb_game_control;

    logic        clock;
    logic        reset;
    logic        pause;
    logic        idle_done;
    logic        draw_map_done;
    logic        draw_link_done;
    logic        draw_enemies_done;
    logic        init;
    logic        idle;
    logic        gen_move;
    logic        check_collide;
    logic        apply_act_link;
    logic        move_enemies;
    logic        draw_map;
    logic        draw_link;
    logic        draw_enemies;
    logic [15:0] frame_count;
    logic        timeout_flag;
    logic [3:0]  state_dbg;

    logic [8:0]  w_strobes;

    int total = 0;
    int bad   = 0;

    game_control #(
        .INIT_CYCLES  (4),
        .DRAW_TIMEOUT (24'd16)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .pause             (pause),
        .idle_done         (idle_done),
        .draw_map_done     (draw_map_done),
        .draw_link_done    (draw_link_done),
        .draw_enemies_done (draw_enemies_done),
        .init              (init),
        .idle              (idle),
        .gen_move          (gen_move),
        .check_collide     (check_collide),
        .apply_act_link    (apply_act_link),
        .move_enemies      (move_enemies),
        .draw_map          (draw_map),
        .draw_link         (draw_link),
        .draw_enemies      (draw_enemies),
        .frame_count       (frame_count),
        .timeout_flag      (timeout_flag),
        .state_dbg         (state_dbg)
    );

    assign w_strobes = {draw_enemies, draw_link, draw_map, move_enemies, apply_act_link,
                        check_collide, gen_move, idle, init};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [8:0] oh(input int n);
        logic [8:0] v;
        v = 9'd1;
        return v << n;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_done(input int idx, input logic v);
        case (idx)
            0:       draw_map_done     = v;
            1:       draw_link_done    = v;
            default: draw_enemies_done = v;
        endcase
    endtask

    // Pulse idle_done from S_IDLE and walk the four one-cycle update stages.
    task automatic start_frame(input string tag);
        check({tag, "_idle"}, 32'(w_strobes), 32'(oh(1)));
        idle_done = 1'b1;
        tick();
        idle_done = 1'b0;
        for (int s = 2; s <= 5; s++) begin
            check($sformatf("%s_stage%0d", tag, s), 32'(w_strobes), 32'(oh(s)));
            check($sformatf("%s_dbg%0d", tag, s), 32'(state_dbg), s);
            tick();
        end
    endtask

    // Expect draw stage idx to hold for exp_len cycles; raise its done after check k==done_at.
    task automatic draw_stage(input string tag, input int idx, input int done_at, input int exp_len);
        for (int k = 0; k < exp_len; k++) begin
            check($sformatf("%s_draw%0d_c%0d", tag, idx, k), 32'(w_strobes), 32'(oh(6 + idx)));
            if (k == done_at) set_done(idx, 1'b1);
            tick();
        end
        set_done(idx, 1'b0);
    endtask

    initial begin
        reset             = 1'b0;
        pause             = 1'b0;
        idle_done         = 1'b0;
        draw_map_done     = 1'b0;
        draw_link_done    = 1'b0;
        draw_enemies_done = 1'b0;

        // Reset held three edges, then four init edges.
        repeat (3) tick();
        check("rst_strobes", 32'(w_strobes), 32'(oh(0)));
        check("rst_dbg", 32'(state_dbg), 0);
        check("rst_frames", 32'(frame_count), 0);
        check("rst_flag", 32'(timeout_flag), 0);
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("init_edge%0d", i), 32'(w_strobes), 32'(oh(0)));
        end
        tick();
        check("init_to_idle", 32'(w_strobes), 32'(oh(1)));
        check("idle_dbg", 32'(state_dbg), 1);
        check("idle_frames", 32'(frame_count), 0);
        check("idle_flag", 32'(timeout_flag), 0);

        // Frame 1: every drawer answers three cycles after its strobe rises.
        start_frame("f1");
        draw_stage("f1", 0, 3, 4);
        draw_stage("f1", 1, 3, 4);
        draw_stage("f1", 2, 3, 4);
        check("f1_back_idle", 32'(w_strobes), 32'(oh(1)));
        check("f1_frames", 32'(frame_count), 1);

        // Frame 2: stale draw_link_done held high is masked for one cycle only.
        draw_link_done = 1'b1;
        start_frame("f2");
        draw_stage("f2", 0, 3, 4);
        draw_stage("f2", 1, -1, 2);
        draw_stage("f2", 2, 3, 4);
        check("f2_frames", 32'(frame_count), 2);
        check("f2_flag", 32'(timeout_flag), 0);

        // Frame 3: map done lands on the same edge as the watchdog expiry.
        start_frame("f3");
        draw_stage("f3", 0, 15, 16);
        check("f3_link", 32'(w_strobes), 32'(oh(7)));
        check("f3_flag_clear", 32'(timeout_flag), 0);
        draw_stage("f3", 1, 3, 4);
        draw_stage("f3", 2, 3, 4);
        check("f3_frames", 32'(frame_count), 3);

        // Frame 4: map done never comes; watchdog forces advance after 16 cycles.
        start_frame("f4");
        draw_stage("f4", 0, -1, 16);
        check("f4_link", 32'(w_strobes), 32'(oh(7)));
        check("f4_flag_set", 32'(timeout_flag), 1);
        draw_stage("f4", 1, 3, 4);
        draw_stage("f4", 2, 3, 4);
        check("f4_frames", 32'(frame_count), 4);

        // Frame 5: normal frame, flag stays sticky; idle_done during draw_map is ignored.
        start_frame("f5");
        idle_done = 1'b1;
        draw_stage("f5", 0, 3, 4);
        idle_done = 1'b0;
        draw_stage("f5", 1, 3, 4);
        draw_stage("f5", 2, 3, 4);
        check("f5_idle", 32'(w_strobes), 32'(oh(1)));
        check("f5_frames", 32'(frame_count), 5);
        check("f5_flag_sticky", 32'(timeout_flag), 1);

        // Pause holds S_IDLE even with idle_done high.
        pause     = 1'b1;
        idle_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("pause_c%0d", i), 32'(w_strobes), 32'(oh(1)));
        end
        pause     = 1'b0;
        idle_done = 1'b0;

        // Preload the frame counter to its top value and complete one frame.
        force dut.r_frame_count = 16'hFFFF;
        tick();
        release dut.r_frame_count;
        tick();
        check("wrap_preload", 32'(frame_count), 32'h0000FFFF);
        start_frame("f6");
        draw_stage("f6", 0, 3, 4);
        draw_stage("f6", 1, 3, 4);
        draw_stage("f6", 2, 3, 4);
        check("wrap_frames", 32'(frame_count), 0);

        // Reset asserted while draw_link is active.
        start_frame("f7");
        draw_stage("f7", 0, 3, 4);
        check("f7_link", 32'(w_strobes), 32'(oh(7)));
        reset = 1'b0;
        tick();
        check("midrst_strobes", 32'(w_strobes), 32'(oh(0)));
        check("midrst_dbg", 32'(state_dbg), 0);
        check("midrst_frames", 32'(frame_count), 0);
        check("midrst_flag", 32'(timeout_flag), 0);
        reset = 1'b1;
        repeat (3) tick();
        check("midrst_init", 32'(w_strobes), 32'(oh(0)));
        tick();
        check("midrst_idle", 32'(w_strobes), 32'(oh(1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_control.md
Name: game_control

Overview:
Top-level game FSM that sequences the per-frame datapath stages. It drives the datapath stage strobes: init, idle, gen_move, check_collide, apply_act_link, move_enemies, draw_map, draw_link and draw_enemies. It consumes idle_done, draw_map_done, draw_link_done and draw_enemies_done. A draw watchdog prevents a stalled sprite/map drawer from hanging the frame loop. Frame count, sticky error and state outputs are provided for LEDs/HEX.

Parameters:
INIT_CYCLES, 4, cycles spent in S_INIT after reset release (min 1)
DRAW_TIMEOUT, 24'd200000, max cycles in any draw state before forced advance (min 2)

Ports:
clock  in  1  system clock (CLOCK_50)
reset  in  1  synchronous, active-low reset
pause  in  1  hold in S_IDLE while high
idle_done  in  1  frame tick from datapath
draw_map_done  in  1  map drawer finished
draw_link_done  in  1  link drawer finished
draw_enemies_done  in  1  enemy drawer finished
init  out  1  high in S_INIT
idle  out  1  high in S_IDLE
gen_move  out  1  high in S_GEN_MOVE
check_collide  out  1  high in S_CHECK_COLLIDE
apply_act_link  out  1  high in S_APPLY_ACT_LINK
move_enemies  out  1  high in S_MOVE_ENEMIES
draw_map  out  1  high in S_DRAW_MAP
draw_link  out  1  high in S_DRAW_LINK
draw_enemies  out  1  high in S_DRAW_ENEMIES
frame_count  out  16  completed frames, wraps
timeout_flag  out  1  sticky: some draw state timed out
state_dbg  out  4  current state encoding

Behaviour:
- Clocking and reset:
  - Single clock domain; all registers update on posedge clock.
  - Reset is synchronous, active-low: reset==0 at an edge sets state=S_INIT, init counter=0, watchdog=0, frame_count=0, timeout_flag=0.
- State encoding: S_INIT=0, S_IDLE=1, S_GEN_MOVE=2, S_CHECK_COLLIDE=3, S_APPLY_ACT_LINK=4, S_MOVE_ENEMIES=5, S_DRAW_MAP=6, S_DRAW_LINK=7, S_DRAW_ENEMIES=8.
  - Codes 9-15 are illegal: go to S_INIT on the next edge, with all strobes 0 while in them.
- Outputs:
  - Strobes are a Moore decode of the state register; exactly one strobe is high in any legal state.
  - During/after reset: init=1, all other strobes 0, state_dbg=0.
- Transitions (reset high):
  - S_INIT: stay INIT_CYCLES cycles (counter 0..INIT_CYCLES-1), then S_IDLE.
  - S_IDLE: go to S_GEN_MOVE on an edge where idle_done==1 and pause==0; otherwise stay.
  - S_GEN_MOVE -> S_CHECK_COLLIDE -> S_APPLY_ACT_LINK -> S_MOVE_ENEMIES -> S_DRAW_MAP, one cycle each, unconditional.
  - S_DRAW_MAP -> S_DRAW_LINK on draw_map_done.
  - S_DRAW_LINK -> S_DRAW_ENEMIES on draw_link_done.
  - S_DRAW_ENEMIES -> S_IDLE on draw_enemies_done.
- Done arming:
  - In each draw state the done input is ignored on the first cycle of the state; it is sampled from the second cycle on.
  - This masks stale done levels left from the previous stage/frame, so the minimum dwell per draw state is 2 cycles.
- Latency: idle_done sampled high to draw_map asserted = 5 edges.
- Watchdog:
  - 24-bit counter, cleared on every state change, increments each cycle in a draw state.
  - When it equals DRAW_TIMEOUT-1 with no qualified done, the FSM advances as if done had arrived and sets timeout_flag=1.
  - timeout_flag is cleared only by reset.
  - Done and timeout on the same edge: advance once, and timeout_flag is NOT set.
- frame_count increments by 1 on the S_DRAW_ENEMIES -> S_IDLE transition, including a timeout-forced one; 16'hFFFF wraps to 0.
- pause has no effect outside S_IDLE; a frame in progress completes.
- Reset asserted mid-frame, in any state: the next edge goes to S_INIT, all strobes except init drop that edge, and counters clear.
- idle_done high while in S_INIT or a draw state is ignored.

Test Plan:
- Reset/init (INIT_CYCLES=4): hold reset=0 3 cycles, then release -> init=1 for exactly 4 edges, then idle=1, state_dbg=1, frame_count=0, timeout_flag=0.
- Full frame: in S_IDLE pulse idle_done; each drawer raises done 3 cycles after its draw strobe rises -> gen_move, check_collide, apply_act_link, move_enemies each high exactly 1 cycle, draw_map/draw_link/draw_enemies each high 4 cycles, back to idle, frame_count=1.
- Stale done: hold draw_link_done=1 constantly, map done after 3 cycles -> draw_link still lasts exactly 2 cycles (first-cycle mask), no timeout_flag.
- Timeout (DRAW_TIMEOUT=16): never assert draw_map_done -> draw_map high exactly 16 cycles, then draw_link=1, timeout_flag=1 and it stays 1 through the next complete frame.
- Pause and wrap: pause=1 with idle_done=1 for 10 cycles -> stays idle. Then preload frame_count to 16'hFFFF via 65535 fast frames (or force) and run one frame -> frame_count=0.
- Mid-frame reset: assert reset=0 while draw_link=1 -> next edge draw_link=0, init=1, frame_count=0, state_dbg=0.
